// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM states,
// Wishbone byte selects and the ASCII tag base.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        POLL_W,
        WR,
        WR_W
    } arb_state_t;

    localparam logic [3:0] SEL_WORD  = 4'hF;
    localparam logic [3:0] SEL_BYTE0 = 4'h1;
    localparam logic [7:0] TAG_BASE  = 8'h30;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// N-wide round-robin picker: first request at or after the pointer wins.
// The pointer moves to one past the retiring owner when i_adv is pulsed.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_adv,
    input  logic [N_REQ-1:0] i_adv_gnt,
    output logic [N_REQ-1:0] o_grant
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    always_comb begin
        int   w_idx;
        logic w_found;
        w_idx   = 0;
        w_found = 1'b0;
        o_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_adv_gnt[i]) begin
                w_ptr_nxt = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of a Wishbone UART TX between byte-stream requesters.
// Define UART_ARB_TAG_EN to prefix every message with an ASCII owner tag.
//
// state  | meaning
// IDLE   | no owner; arbitrate among req_valid
// POLL   | read strobe to TX control register
// POLL_W | wait for poll response, then for owner's byte (cyc low after resp)
// WR     | write strobe to TX data register
// WR_W   | wait for write response, then pop byte / retire message
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [31:0] TX_CTRL_ADDR = 32'h0,
    parameter logic [31:0] TX_DATA_ADDR = 32'h0,
    parameter int          FULL_BIT     = 2,
    parameter int          ACK_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               err,
    output logic               m_cyc,
    output logic               m_stb,
    output logic               m_we,
    output logic [31:0]        m_addr,
    output logic [3:0]         m_sel,
    output logic [31:0]        m_data_m2s,
    input  logic [31:0]        m_data_s2m,
    input  logic               m_ack,
    input  logic               m_err,
    input  logic               m_stall
);
`ifdef UART_ARB_TAG_EN
    localparam logic TAG_EN = 1'b1;
`else
    localparam logic TAG_EN = 1'b0;
`endif
    localparam logic [7:0] TMO_LOAD = 8'(ACK_TIMEOUT);

    arb_state_t       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic             r_resp, w_resp_nxt;
    logic             r_retry, w_retry_nxt;
    logic             r_tag, w_tag_nxt;
    logic [7:0]       r_tmo, w_tmo_nxt;
    logic             r_err, w_err_nxt;
    logic             w_arb_adv;
    logic             w_timeout;
    logic [N_REQ-1:0] w_arb_gnt;
    logic [7:0]       w_byte, w_tx_byte;
    logic             w_gnt_valid, w_gnt_last;
    logic [2:0]       w_gnt_idx;
    logic             w_unused_s2m;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .i_adv     (w_arb_adv),
        .i_adv_gnt (r_grant),
        .o_grant   (w_arb_gnt)
    );

    always_comb begin
        w_byte      = '0;
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_byte      = req_data[8*i +: 8];
                w_gnt_valid = req_valid[i];
                w_gnt_last  = req_last[i];
                w_gnt_idx   = 3'(i);
            end
        end
    end

    assign w_tx_byte    = r_tag ? (TAG_BASE + {5'd0, w_gnt_idx}) : w_byte;
    assign w_unused_s2m = ^m_data_s2m;
    assign grant        = r_grant;
    assign busy         = (r_state != IDLE);
    assign err          = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_resp_nxt  = r_resp;
        w_retry_nxt = r_retry;
        w_tag_nxt   = r_tag;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        w_arb_adv   = 1'b0;
        w_timeout   = (r_tmo == 8'd0);
        m_cyc       = 1'b0;
        m_stb       = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_sel       = '0;
        m_data_m2s  = '0;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                w_resp_nxt  = 1'b0;
                w_retry_nxt = 1'b0;
                if (|req_valid) begin
                    w_grant_nxt = w_arb_gnt;
                    w_tag_nxt   = TAG_EN;
                    w_state_nxt = POLL;
                end
            end
            POLL: begin
                m_cyc       = 1'b1;
                m_stb       = 1'b1;
                m_addr      = TX_CTRL_ADDR;
                m_sel       = SEL_WORD;
                w_resp_nxt  = 1'b0;
                w_retry_nxt = 1'b0;
                if (!m_stall) begin
                    w_tmo_nxt   = TMO_LOAD;
                    w_state_nxt = POLL_W;
                end
            end
            POLL_W: begin
                if (!r_resp) begin
                    m_cyc = 1'b1;
                    if (m_err || (!m_ack && w_timeout)) begin
                        w_err_nxt   = 1'b1;
                        w_resp_nxt  = 1'b1;
                        w_retry_nxt = 1'b1;
                    end else if (m_ack) begin
                        w_resp_nxt  = 1'b1;
                        w_retry_nxt = m_data_s2m[FULL_BIT];
                    end else begin
                        w_tmo_nxt = r_tmo - 8'd1;
                    end
                end else if (r_retry) begin
                    w_state_nxt = POLL;
                end else if (r_tag || w_gnt_valid) begin
                    w_state_nxt = WR;
                end
            end
            WR: begin
                m_cyc      = 1'b1;
                m_stb      = 1'b1;
                m_we       = 1'b1;
                m_addr     = TX_DATA_ADDR;
                m_sel      = SEL_BYTE0;
                m_data_m2s = {24'h0, w_tx_byte};
                w_resp_nxt = 1'b0;
                if (!m_stall) begin
                    w_tmo_nxt   = TMO_LOAD;
                    w_state_nxt = WR_W;
                end
            end
            WR_W: begin
                if (!r_resp) begin
                    m_cyc = 1'b1;
                    // a failed write still retires the byte so the bus cannot wedge
                    if (m_err || (!m_ack && w_timeout)) begin
                        w_err_nxt  = 1'b1;
                        w_resp_nxt = 1'b1;
                    end else if (m_ack) begin
                        w_resp_nxt = 1'b1;
                    end else begin
                        w_tmo_nxt = r_tmo - 8'd1;
                    end
                end else begin
                    w_tag_nxt = 1'b0;
                    if (r_tag) begin
                        w_state_nxt = POLL;
                    end else begin
                        req_ready = r_grant;
                        if (w_gnt_last) begin
                            w_arb_adv   = 1'b1;
                            w_grant_nxt = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = POLL;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_resp  <= 1'b0;
            r_retry <= 1'b0;
            r_tag   <= 1'b0;
            r_tmo   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_resp  <= w_resp_nxt;
            r_retry <= w_retry_nxt;
            r_tag   <= w_tag_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: a negedge Wishbone slave model checks
// every accepted write and req_ready pulse against queued expectations.
module tb_uart_tx_arb;
    localparam int          N    = 4;
    localparam logic [31:0] CTRL = 32'h10;
    localparam logic [31:0] DATA = 32'h14;
`ifdef UART_ARB_TAG_EN
    localparam int T = 1;
`else
    localparam int T = 0;
`endif

    typedef struct {int idx; logic [7:0] d; logic last;} src_t;
    typedef struct {int idx; logic [7:0] d;} wr_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           busy, err, m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
    logic [31:0]    m_addr, m_data_m2s, m_data_s2m;
    logic [3:0]     m_sel;

    src_t src_q[$];
    wr_t  exp_wr[$];
    int   exp_rdy[$];
    logic [N-1:0] pop_pend = '0;

    int n_checks = 0, n_errors = 0;
    int n_rd = 0, n_wr = 0, n_rdy = 0, n_stalled = 0;
    int cyc_n = 0, last_wr_cyc = -1;
    int full_cnt = 0, stall_wr = 0;
    bit noack_wr = 0, gap_chk = 0, pend = 0, pend_we = 0;

    uart_tx_arb #(.N_REQ(N), .TX_CTRL_ADDR(CTRL), .TX_DATA_ADDR(DATA),
                  .FULL_BIT(2), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
        .err(err), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
        .m_sel(m_sel), .m_data_m2s(m_data_m2s), .m_data_s2m(m_data_s2m),
        .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // slave model and requester sources, all updated mid-cycle
    always @(negedge clk) begin
        wr_t w;
        int  e;
        cyc_n++;
        for (int i = 0; i < N; i++) begin
            if (pop_pend[i]) begin
                for (int j = 0; j < src_q.size(); j++) begin
                    if (src_q[j].idx == i) begin
                        src_q.delete(j);
                        break;
                    end
                end
                pop_pend[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            for (int j = src_q.size() - 1; j >= 0; j--) begin
                if (src_q[j].idx == i) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = src_q[j].last;
                    req_data[8*i +: 8] = src_q[j].d;
                end
            end
        end
        m_ack      = pend && !(pend_we && noack_wr);
        m_data_s2m = 32'h0;
        if (m_ack && !pend_we && full_cnt > 0) begin
            m_data_s2m = 32'h4;
            full_cnt--;
        end
        if (req_ready != '0) begin
            n_rdy++;
            for (int i = 0; i < N; i++) if (req_ready[i]) pop_pend[i] = 1'b1;
            if (exp_rdy.size() == 0) chk("rdy_unexpected", 32'(req_ready), 32'h0);
            else begin
                e = exp_rdy.pop_front();
                chk("rdy_onehot", 32'(req_ready), 32'h1 << e);
            end
        end
        m_stall = 1'b0;
        if (m_cyc && m_stb && m_we && stall_wr > 0) begin
            m_stall = 1'b1;
            stall_wr--;
            n_stalled++;
            chk("stall_addr", m_addr, DATA);
            if (exp_wr.size() > 0) chk("stall_data", m_data_m2s, {24'h0, exp_wr[0].d});
        end
        pend    = m_cyc && m_stb && !m_stall;
        pend_we = m_we;
        if (pend) begin
            if (m_we) begin
                n_wr++;
                if (gap_chk && last_wr_cyc >= 0) chk("wr_gap", cyc_n - last_wr_cyc, 6);
                last_wr_cyc = cyc_n;
                if (exp_wr.size() == 0) chk("wr_unexpected", m_data_m2s, 32'hFFFF_FFFF);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_data", m_data_m2s, {24'h0, w.d});
                    chk("wr_sel", 32'(m_sel), 32'h1);
                    chk("wr_addr", m_addr, DATA);
                    chk("wr_grant", 32'(grant), 32'h1 << w.idx);
                end
            end else begin
                n_rd++;
                chk("rd_addr", m_addr, CTRL);
                chk("rd_sel", 32'(m_sel), 32'hF);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input int idx, input logic [7:0] d, input logic last, input logic first);
        if (T == 1 && first) exp_wr.push_back('{idx: idx, d: 8'h30 + 8'(idx)});
        exp_wr.push_back('{idx: idx, d: d});
        exp_rdy.push_back(idx);
        src_q.push_back('{idx: idx, d: d, last: last});
    endtask

    task automatic clr_cnt();
        n_rd = 0; n_wr = 0; n_rdy = 0; n_stalled = 0; last_wr_cyc = -1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (!(src_q.size() == 0 && exp_wr.size() == 0 && exp_rdy.size() == 0 && !busy)
               && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(n < max), 32'h1);
    endtask

    initial begin
        int n;
        rst = 1'b1; m_err = 1'b0; m_ack = 1'b0; m_stall = 1'b0;
        m_data_s2m = '0; req_valid = '0; req_last = '0; req_data = '0;
        repeat (3) step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cyc", 32'(m_cyc), 0);
        chk("rst_stb", 32'(m_stb), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        step();

        // three-byte message from req0
        clr_cnt(); gap_chk = 1;
        send_byte(0, 8'h41, 0, 1);
        send_byte(0, 8'h42, 0, 0);
        send_byte(0, 8'h43, 1, 0);
        wait_idle("t1_done", 200);
        gap_chk = 0;
        chk("t1_reads", n_rd, 3 + T);
        chk("t1_writes", n_wr, 3 + T);
        chk("t1_readys", n_rdy, 3);
        chk("t1_grant_idle", 32'(grant), 0);

        // req1 and req2 contend; req1 wins, then req2, then pointer at 3
        clr_cnt();
        send_byte(1, 8'h10, 0, 1);
        send_byte(1, 8'h11, 1, 0);
        send_byte(2, 8'h20, 0, 1);
        send_byte(2, 8'h21, 1, 0);
        wait_idle("t2_done", 300);
        chk("t2_writes", n_wr, 4 + 2 * T);
        clr_cnt();
        send_byte(3, 8'h33, 1, 1);
        send_byte(0, 8'h00, 1, 1);
        wait_idle("t2_rr_done", 200);
        chk("t2_rr_readys", n_rdy, 2);

        // FIFO full on two polls
        clr_cnt(); full_cnt = 2;
        send_byte(3, 8'h99, 1, 1);
        wait_idle("t3_done", 200);
        chk("t3_reads", n_rd, 3 + T);
        chk("t3_writes", n_wr, 1 + T);
        chk("t3_readys", n_rdy, 1);

        // 4-cycle stall on write
        clr_cnt(); stall_wr = 4;
        send_byte(1, 8'hC3, 1, 1);
        wait_idle("t4_done", 200);
        chk("t4_stalled", n_stalled, 4);
        chk("t4_writes", n_wr, 1 + T);

        // write never acked: timeout, byte still consumed
        clr_cnt(); noack_wr = 1;
        send_byte(0, 8'h77, 1, 1);
        n = 0;
        while (n_wr == 0 && n < 100) begin step(); n++; end
        chk("t5_wr_seen", 32'(n < 100), 1);
        repeat (200) step();
        chk("t5_err_early", 32'(err), 0);
        wait_idle("t5_done", 1200);
        chk("t5_err_set", 32'(err), 1);
        chk("t5_readys", n_rdy, 1);
        noack_wr = 0;
        clr_cnt();
        send_byte(2, 8'h5A, 1, 1);
        wait_idle("t6_done", 200);
        chk("t5_err_sticky", 32'(err), 1);
        chk("t6_writes", n_wr, 1 + T);
        chk("t6_readys", n_rdy, 1);

        // reset mid-transaction
        clr_cnt();
        send_byte(0, 8'h11, 1, 1);
        n = 0;
        while (!(m_stb && !m_we) && n < 50) begin step(); n++; end
        chk("t7_poll_seen", 32'(n < 50), 1);
        rst = 1'b1;
        step();
        chk("t7_cyc_drop", 32'(m_cyc), 0);
        chk("t7_err_clr", 32'(err), 0);
        chk("t7_grant_clr", 32'(grant), 0);
        src_q.delete(); exp_wr.delete(); exp_rdy.delete();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("t7_no_ready", n_rdy, 0);
        chk("t7_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
